// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with per-digit dp/blank, leading-zero
// suppression, PWM brightness and a double-buffered, frame-synchronous data update.
module seg7_scan_ctrl #(
    parameter int N_DIGITS   = 8,
    parameter int DIV_W      = 32,
    parameter int BRIGHT_W   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_W-1:0]      div_value,
    input  logic [4*N_DIGITS-1:0] din,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  load,
    output logic                  upd_done,
    output logic                  frame_tick,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int              IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
    logic                  pending_q, pending_d;
    logic [4*N_DIGITS-1:0] act_din_q, act_din_d, stg_din_q, stg_din_d;
    logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, stg_dp_q, stg_dp_d;
    logic [N_DIGITS-1:0]   act_blank_q, act_blank_d, stg_blank_q, stg_blank_d;
    logic                  act_lz_q, act_lz_d, stg_lz_q, stg_lz_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  upd_done_q, upd_done_d;

    logic                  tick, wrap, pwm_on, all_zero, anode_on, digit_on;
    logic [N_DIGITS-1:0]   suppressed, an_raw;
    logic [3:0]            nib;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        tick         = (cnt_q >= div_value);
        wrap         = tick && (idx_q == LAST_IDX);
        cnt_d        = tick ? '0 : cnt_q + DIV_W'(1);
        idx_d        = idx_q;
        if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        pwm_d        = pwm_q + BRIGHT_W'(1);
        frame_tick_d = wrap;
        upd_done_d   = wrap && pending_q;

        act_din_d   = act_din_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        act_lz_d    = act_lz_q;
        if (wrap && pending_q) begin
            act_din_d   = stg_din_q;
            act_dp_d    = stg_dp_q;
            act_blank_d = stg_blank_q;
            act_lz_d    = stg_lz_q;
        end

        // A load coinciding with a wrap lands in staging and waits for the next wrap.
        stg_din_d   = stg_din_q;
        stg_dp_d    = stg_dp_q;
        stg_blank_d = stg_blank_q;
        stg_lz_d    = stg_lz_q;
        pending_d   = pending_q && !wrap;
        if (load) begin
            stg_din_d   = din;
            stg_dp_d    = dp_in;
            stg_blank_d = blank_in;
            stg_lz_d    = lz_en;
            pending_d   = 1'b1;
        end

        // Scan from the most significant digit down, tracking "everything above is zero".
        all_zero   = 1'b1;
        suppressed = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            all_zero      = all_zero && (act_din_q[4*k +: 4] == 4'h0);
            suppressed[k] = act_lz_q && all_zero && (k != 0);
        end

        pwm_on   = (brightness == {BRIGHT_W{1'b1}}) || (pwm_q < brightness);
        nib      = act_din_q[4*idx_q +: 4];
        digit_on = !act_blank_q[idx_q] && pwm_on && !suppressed[idx_q];
        anode_on = !act_blank_q[idx_q] && pwm_on && (!suppressed[idx_q] || act_dp_q[idx_q]);

        an_raw        = '0;
        an_raw[idx_q] = anode_on;
        an_d  = ACTIVE_LOW ? ~an_raw : an_raw;
        seg_d = digit_on ? hex_to_seg(nib) : 7'h00;
        if (ACTIVE_LOW) seg_d = ~seg_d;
        dp_d  = (anode_on && act_dp_q[idx_q]) ^ ACTIVE_LOW;
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            pending_q    <= 1'b0;
            act_din_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            act_lz_q     <= 1'b0;
            stg_din_q    <= '0;
            stg_dp_q     <= '0;
            stg_blank_q  <= '1;
            stg_lz_q     <= 1'b0;
            an_q         <= {N_DIGITS{ACTIVE_LOW}};
            seg_q        <= {7{ACTIVE_LOW}};
            dp_q         <= ACTIVE_LOW;
            frame_tick_q <= 1'b0;
            upd_done_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            pending_q    <= pending_d;
            act_din_q    <= act_din_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_lz_q     <= act_lz_d;
            stg_din_q    <= stg_din_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            stg_lz_q     <= stg_lz_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
            upd_done_q   <= upd_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;
    assign upd_done   = upd_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (8 digits, active-low): a frame-level behavioural
// model predicts every output each cycle, plus directed scenarios with literal expectations.
module tb_seg7_scan_ctrl;

    localparam int N = 8;

    // Active-high segment patterns for hex 0..F.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] div_value;
    logic [31:0] din;
    logic [7:0]  dp_in, blank_in;
    logic        lz_en, load;
    logic [3:0]  brightness;
    logic        upd_done, frame_tick, dp;
    logic [7:0]  an;
    logic [6:0]  seg;

    seg7_scan_ctrl #(.N_DIGITS(8), .DIV_W(32), .BRIGHT_W(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .div_value(div_value), .din(din), .dp_in(dp_in),
        .blank_in(blank_in), .lz_en(lz_en), .brightness(brightness), .load(load),
        .upd_done(upd_done), .frame_tick(frame_tick), .an(an), .seg(seg), .dp(dp));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state: scan position, PWM phase, displayed and staged frames.
    logic [31:0] m_cnt;
    int          m_idx, m_pwm;
    bit          m_pending;
    logic [31:0] m_act_din, m_stg_din;
    logic [7:0]  m_act_dp, m_stg_dp, m_act_blank, m_stg_blank;
    bit          m_act_lz, m_stg_lz;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_ft, exp_ud;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic bit wrap_next();
        return !rst && (m_cnt >= div_value) && (m_idx == N - 1);
    endfunction

    task automatic model_step();
        bit         pwm_on, supp, lit, shown, tick, wrap;
        logic [3:0] nib;
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_pwm = 0; m_pending = 0;
            m_act_din = 0; m_stg_din = 0; m_act_dp = 0; m_stg_dp = 0;
            m_act_blank = 8'hFF; m_stg_blank = 8'hFF; m_act_lz = 0; m_stg_lz = 0;
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 0; exp_ud = 0;
            return;
        end
        pwm_on = (brightness == 4'hF) || (m_pwm < int'(brightness));
        nib    = m_act_din[m_idx*4 +: 4];
        supp   = m_act_lz && (m_idx != 0) && ((m_act_din >> (4*m_idx)) == 0);
        shown  = !m_act_blank[m_idx] && pwm_on && !supp;
        lit    = !m_act_blank[m_idx] && pwm_on && (!supp || m_act_dp[m_idx]);
        exp_an  = ~(lit ? (8'd1 << m_idx) : 8'd0);
        exp_seg = ~(shown ? SEG_TAB[nib] : 7'd0);
        exp_dp  = !(lit && m_act_dp[m_idx]);

        tick   = (m_cnt >= div_value);
        wrap   = tick && (m_idx == N - 1);
        exp_ft = wrap;
        exp_ud = wrap && m_pending;
        if (wrap && m_pending) begin
            m_act_din = m_stg_din; m_act_dp = m_stg_dp;
            m_act_blank = m_stg_blank; m_act_lz = m_stg_lz;
        end
        if (load) begin
            m_stg_din = din; m_stg_dp = dp_in; m_stg_blank = blank_in; m_stg_lz = lz_en;
            m_pending = 1;
        end else if (wrap) begin
            m_pending = 0;
        end
        m_cnt = tick ? 32'd0 : m_cnt + 32'd1;
        if (tick) m_idx = (m_idx + 1) % N;
        m_pwm = (m_pwm + 1) % 16;
    endtask

    // One clock: model advances on the edge, DUT outputs are compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("dp", 32'(dp), 32'(exp_dp));
        check("frame_tick", 32'(frame_tick), 32'(exp_ft));
        check("upd_done", 32'(upd_done), 32'(exp_ud));
    endtask

    task automatic wait_upd(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            cycle();
            if (upd_done) break;
        end
        check({name, "_upd_seen"}, 32'(k < budget), 32'd1);
    endtask

    task automatic goto_wrap(input string name);
        int k;
        for (k = 0; k < 400 && !wrap_next(); k++) cycle();
        check({name, "_wrap_found"}, 32'(wrap_next()), 32'd1);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b, input bit lz);
        din = d; dp_in = p; blank_in = b; lz_en = lz; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        int t0, n_a, n_b, n_c, n_d, run;
        logic [7:0] an_e, an_e1;

        rst = 1'b1; div_value = 0; din = 0; dp_in = 0; blank_in = 0;
        lz_en = 0; load = 0; brightness = 4'hF;

        // Scenario 1: reset, then idle scanning with the all-blank reset frame.
        cycle(); cycle();
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_upd", 32'(upd_done), 32'h0);
        rst = 1'b0; div_value = 3;
        n_a = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (an != 8'hFF || upd_done) n_a++;
        end
        check("idle_dark", 32'(n_a), 32'd0);

        // Scenario 2: full data, 4-cycle slots, 32-cycle frame.
        do_load(32'h76543210, 8'h00, 8'h00, 1'b0);
        wait_upd(80, "s2");
        check("s2_ft_with_upd", 32'(frame_tick), 32'd1);
        t0 = cyc; n_a = 0; n_b = 0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (an == 8'hFB) n_a++;
            if (an == 8'hFB && seg == 7'h24 && dp) n_b++;
            if (frame_tick) break;
        end
        check("s2_frame_period", 32'(cyc - t0), 32'd32);
        check("s2_digit2_cycles", 32'(n_a), 32'd4);
        check("s2_digit2_seg", 32'(n_b), 32'd4);

        // Scenario 3: leading-zero suppression with a dp on a suppressed digit.
        do_load(32'h00000A05, 8'h20, 8'h00, 1'b1);
        wait_upd(80, "s3");
        n_a = 0; n_b = 0; n_c = 0; n_d = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            if (an == 8'hDF) n_a++;
            if (an == 8'hDF && seg == 7'h7F && !dp) n_b++;
            if ((~an & 8'hD8) != 0) n_c++;
            if ((~an & 8'h07) != 0) n_d++;
        end
        check("s3_d5_cycles", 32'(n_a), 32'd4);
        check("s3_d5_dp_only", 32'(n_b), 32'd4);
        check("s3_suppressed_on", 32'(n_c), 32'd0);
        check("s3_lit_cycles", 32'(n_d), 32'd12);

        // Scenario 4: PWM duty 4/16, then brightness 0.
        do_load(32'h12345678, 8'h00, 8'h00, 1'b0);
        wait_upd(80, "s4");
        brightness = 4'h4; div_value = 31;
        n_a = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (an != 8'hFF) n_a++;
        end
        check("s4_duty4", 32'(n_a), 32'd64);
        brightness = 4'h0;
        cycle();
        n_a = 0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (an != 8'hFF) n_a++;
        end
        check("s4_bright0_dark", 32'(n_a), 32'd0);

        // Scenario 5: load B in the very cycle of the wrap that applies pending A.
        brightness = 4'hF; div_value = 3;
        goto_wrap("s5a");
        cycle();
        do_load(32'hAAAA5555, 8'h00, 8'h00, 1'b0);
        goto_wrap("s5b");
        do_load(32'h0F0F0F0F, 8'h00, 8'h00, 1'b0);
        check("s5_upd_A", 32'(upd_done), 32'd1);
        check("s5_ft_A", 32'(frame_tick), 32'd1);
        t0 = cyc;
        cycle();
        check("s5_A_an", 32'(an), 32'hFE);
        check("s5_A_seg", 32'(seg), 32'h12);
        wait_upd(64, "s5c");
        check("s5_B_delay", 32'(cyc - t0), 32'd32);
        cycle();
        check("s5_B_seg", 32'(seg), 32'h0E);

        // Scenario 6: shrink div_value while cnt is above it, then reset mid-scan.
        div_value = 100;
        for (int i = 0; i < 300 && m_cnt != 50; i++) cycle();
        check("s6_cnt50_found", m_cnt, 32'd50);
        div_value = 2;
        cycle();
        an_e = an;
        cycle();
        an_e1 = an;
        check("s6_tick_next", 32'(an_e1 != an_e), 32'd1);
        run = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (an != an_e1) break;
            run++;
        end
        check("s6_slot3", 32'(run), 32'd3);
        rst = 1'b1; load = 1'b1;
        cycle();
        rst = 1'b0; load = 1'b0;
        check("s6_rst_an", 32'(an), 32'hFF);
        check("s6_rst_seg", 32'(seg), 32'h7F);
        check("s6_rst_dp", 32'(dp), 32'h1);
        check("s6_rst_ft", 32'(frame_tick), 32'h0);
        for (int i = 0; i < 20; i++) cycle();

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) div_value = $urandom_range(0, 5);
            rst        = ($urandom_range(0, 299) == 0);
            load       = ($urandom_range(0, 19) == 0);
            din        = $urandom >> $urandom_range(0, 31);
            dp_in      = 8'($urandom);
            blank_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            lz_en      = 1'($urandom);
            brightness = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            cycle();
        end
        rst = 1'b0; load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised time-multiplexed 7-segment display controller. It is the successor of the fixed 8-digit scan/mux/decode chain and targets the Nexys4DDR and similar boards. It adds the following, all in one clocked block:
- configurable digit count
- per-digit decimal point and blanking
- leading-zero suppression
- PWM brightness
- double-buffered, frame-synchronous data update

Parameters:
N_DIGITS, 8, number of multiplexed digits (1..16)
DIV_W, 32, width of scan-rate divider
BRIGHT_W, 4, width of brightness control
ACTIVE_LOW, 1, 1 = anodes/segments/dp driven low-active; 0 = high-active

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
div_value  input  DIV_W  scan slot length minus 1, in clk cycles
din  input  4*N_DIGITS  hex nibbles; digit k = din[4k+3:4k], digit 0 rightmost
dp_in  input  N_DIGITS  decimal point per digit, 1 = lit
blank_in  input  N_DIGITS  per-digit blank, 1 = digit dark
lz_en  input  1  leading-zero suppression enable
brightness  input  BRIGHT_W  duty level; 0 = off, all-ones = full on
load  input  1  1-cycle strobe: stage din/dp_in/blank_in/lz_en
upd_done  output  1  1-cycle pulse when staged data becomes active
frame_tick  output  1  1-cycle pulse at each full-scan wrap
an  output  N_DIGITS  digit anodes
seg  output  7  segments, seg[0]=a .. seg[6]=g
dp  output  1  decimal point segment

Behaviour:
- Reset (rst=1 at posedge): all registers and outputs take these values.
  - Internal: cnt=0, idx=0, pwm=0, pending=0.
  - Active and staged registers: din=0, dp=0, blank=all 1s, lz=0.
  - Outputs: an/seg/dp inactive (all 1s if ACTIVE_LOW), frame_tick=0, upd_done=0.
- Reset mid-operation: same state the next cycle, regardless of pending or load.
- Prescaler:
  - cnt increments each clk.
  - When cnt >= div_value: tick, cnt <= 0.
  - Slot length is div_value+1 cycles; div_value=0 gives a tick every cycle.
  - A lowered div_value while cnt exceeds it ticks on the next cycle.
- Digit index:
  - On tick, idx <= idx+1.
  - At idx = N_DIGITS-1, idx <= 0 (wrap). The wrap cycle raises frame_tick for 1 cycle, registered.
- Load handshake:
  - load=1 copies inputs into the staged registers and sets pending. A repeated load before the wrap overwrites the staged registers (last wins).
  - On wrap with pending=1: active <= staged, pending <= 0, upd_done pulses 1 cycle, coincident with frame_tick.
- load and wrap in the same cycle:
  - The wrap transfers the previous staged contents (only if pending was 1).
  - The new data is captured into staged, and pending ends at 1.
  - The new data therefore applies at the following wrap.
- Leading-zero suppression (active lz=1):
  - Digit k is suppressed if active nibbles k..N_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its dp if its dp bit is set.
- Digit enable:
  - on = !blank[idx] && !suppressed(idx) && pwm_on.
  - A suppressed but dp-lit digit: anode on, seg all off, dp on.
- PWM:
  - BRIGHT_W-bit counter pwm increments every clk, free-running.
  - pwm_on = (brightness == all-ones) || (pwm < brightness).
- Decode: standard hex 0-F, active-high form:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Outputs:
  - an one-hot on bit idx when on, otherwise all inactive.
  - seg, dp, an are registered and reflect idx with 1 cycle latency after the idx update.
  - All three are inverted when ACTIVE_LOW=1.
- N_DIGITS=1: every tick is a wrap.

Test Plan:
1. Reset then idle, ACTIVE_LOW=1 -> an=8'hFF, seg=7'h7F, dp=1, no upd_done. Applies even during a scan, because the reset blank register is all 1s.
2. div_value=3, load din=32'h76543210, blank_in=0, brightness=4'hF:
   - upd_done at first wrap.
   - Thereafter each an bit low for exactly 4 cycles in order 0..7.
   - Digit 2 gives seg=~7'h5B.
   - frame_tick period 32 cycles.
3. lz_en=1, din=32'h00000A05, dp_in=8'h20 -> digits 0,1,2 lit; digits 3,4,6,7 anode off; digit 5 anode on with seg=7'h7F, dp=0.
4. brightness=4'h4, div_value=31 -> within each slot the active anode is low for 4 of every 16 cycles. brightness=0 -> an stays 8'hFF.
5. load at the exact wrap cycle, with data A pending and new data B:
   - The wrap shows A, with upd_done=1.
   - B appears at the next wrap with a second upd_done.
6. div_value changed 100->2 while cnt=50 -> tick next cycle, then 3-cycle slots. Assert rst mid-scan -> state of scenario 1 the next cycle.
